video_pattern_generator: RTL

- Sits directly downstream of Video_Sync_Generator.
- Consumes its sync, blank, visible and position outputs, and produces 3-bit-per-channel RGB plus delayed sync for the VGA pins.
- Supports four test patterns (solid, colour bars, checkerboard, scrolling bars), selected per frame.
- Two-stage registered pipeline; sync and blank signals are delayed to stay aligned with pixel data.

---
 rtl/video_pattern_generator_if.sv | 50 +++++
 rtl/video_pattern_generator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_generator_if.sv
`default_nettype none
// ============================================================================
//  Module   : video_pattern_generator_if
//  Purpose  : Bundles the timing inputs, pattern controls and VGA outputs of
//             video_pattern_generator into one interface.
//  Signals  : i_hsync/i_hblank/i_vsync/i_vblank/i_visible  timing from the
//             sync generator; i_hpos/i_vpos 10-bit raster position;
//             i_pattern 2-bit pattern select; i_solid_rgb 9-bit solid colour;
//             o_hsync..o_visible  timing delayed by two clocks;
//             o_red/o_grn/o_blu 3-bit colour; o_frame 8-bit frame counter.
//  Modports : master - sync generator / system side (drives i_*, sees o_*)
//             slave  - pattern generator side (sees i_*, drives o_*)
//  Revision : 1.0  initial release
// ============================================================================
interface video_pattern_generator_if;
  logic       i_hsync;
  logic       i_hblank;
  logic       i_vsync;
  logic       i_vblank;
  logic       i_visible;
  logic [9:0] i_hpos;
  logic [9:0] i_vpos;
  logic [1:0] i_pattern;
  logic [8:0] i_solid_rgb;

  logic       o_hsync;
  logic       o_hblank;
  logic       o_vsync;
  logic       o_vblank;
  logic       o_visible;
  logic [2:0] o_red;
  logic [2:0] o_grn;
  logic [2:0] o_blu;
  logic [7:0] o_frame;

  modport master (
    output i_hsync, i_hblank, i_vsync, i_vblank, i_visible,
    output i_hpos, i_vpos, i_pattern, i_solid_rgb,
    input  o_hsync, o_hblank, o_vsync, o_vblank, o_visible,
    input  o_red, o_grn, o_blu, o_frame
  );

  modport slave (
    input  i_hsync, i_hblank, i_vsync, i_vblank, i_visible,
    input  i_hpos, i_vpos, i_pattern, i_solid_rgb,
    output o_hsync, o_hblank, o_vsync, o_vblank, o_visible,
    output o_red, o_grn, o_blu, o_frame
  );
endinterface
`default_nettype wire

// File: rtl/video_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module   : video_pattern_generator
//  Purpose  : Turns sync-generator timing into 3:3:3 RGB test patterns
//             (solid, colour bars, checkerboard, scrolling bars) through a
//             two-stage registered pipeline; timing signals ride the same
//             two stages so they stay aligned with the pixel colour.
//  Ports    : i_clk    pixel clock
//             i_reset  synchronous reset, active-high
//             bus      video_pattern_generator_if.slave (timing in, RGB,
//                      delayed timing and frame counter out)
//  Options  : BORDER_OUTLINE_EN - when defined, the outermost visible
//             rows/columns are forced to white over every pattern.
//  Revision : 1.0  initial release
// ============================================================================
module video_pattern_generator #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int BAR_SHIFT = 6,
  parameter int CHK_SHIFT = 5
) (
  input  wire logic                  i_clk,
  input  wire logic                  i_reset,
  video_pattern_generator_if.slave   bus
);

  localparam logic [1:0] c_PAT_SOLID   = 2'd0;
  localparam logic [1:0] c_PAT_BARS    = 2'd1;
  localparam logic [1:0] c_PAT_CHECKER = 2'd2;
  localparam logic [1:0] c_PAT_SCROLL  = 2'd3;
  localparam logic [8:0] c_WHITE       = 9'h1FF;
  localparam logic [8:0] c_BLACK       = 9'h000;

  // --------------------------------------------------------------------------
  // Frame-level state: vsync edge detection, latched controls, frame counter
  // --------------------------------------------------------------------------
  logic       r_vsync_prev;
  logic [1:0] r_pattern;
  logic [8:0] r_solid;
  logic [7:0] r_frame;
  logic       w_frame_start;

  assign w_frame_start = bus.i_vsync & ~r_vsync_prev;

  // History resets to 1 so a vsync already high when reset drops is not
  // mistaken for the start of a new frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vsync_prev <= 1'b1;
      r_pattern    <= 2'd0;
      r_solid      <= 9'd0;
      r_frame      <= 8'd0;
    end else begin
      r_vsync_prev <= bus.i_vsync;
      if (w_frame_start) begin
        r_pattern <= bus.i_pattern;
        r_solid   <= bus.i_solid_rgb;
        r_frame   <= r_frame + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 combinational terms
  // --------------------------------------------------------------------------
  logic [2:0] w_bar;
  logic [9:0] w_scroll_sum;
  logic [9:0] w_scroll_shift;
  logic [2:0] w_sbar;
  logic       w_chk;
  logic       w_unused;

  assign w_bar          = bus.i_hpos[BAR_SHIFT+2:BAR_SHIFT];
  // 10-bit add wraps naturally at 1024.
  assign w_scroll_sum   = bus.i_hpos + {2'b00, r_frame};
  assign w_scroll_shift = w_scroll_sum >> BAR_SHIFT;
  assign w_sbar         = w_scroll_shift[2:0];
  assign w_chk          = bus.i_hpos[CHK_SHIFT] ^ bus.i_vpos[CHK_SHIFT];
  assign w_unused       = ^{bus.i_vpos, w_scroll_shift};

`ifdef BORDER_OUTLINE_EN
  localparam logic [9:0] c_H_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] c_V_LAST = 10'(V_VISIBLE - 1);
  logic w_edge;
  assign w_edge = bus.i_visible &&
                  ((bus.i_hpos == 10'd0) || (bus.i_hpos == c_H_LAST) ||
                   (bus.i_vpos == 10'd0) || (bus.i_vpos == c_V_LAST));
`endif

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic       r1_hsync;
  logic       r1_hblank;
  logic       r1_vsync;
  logic       r1_vblank;
  logic       r1_visible;
  logic [1:0] r1_pattern;
  logic [8:0] r1_solid;
  logic [2:0] r1_bar;
  logic [2:0] r1_sbar;
  logic       r1_chk;
`ifdef BORDER_OUTLINE_EN
  logic       r1_edge;
`endif

  // The latched controls are captured alongside the pixel, so the pixel
  // sampled on the frame-start edge still uses the previous frame's pattern
  // and the new one takes effect from the following capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r1_hsync   <= 1'b0;
      r1_hblank  <= 1'b0;
      r1_vsync   <= 1'b0;
      r1_vblank  <= 1'b0;
      r1_visible <= 1'b0;
      r1_pattern <= 2'd0;
      r1_solid   <= 9'd0;
      r1_bar     <= 3'd0;
      r1_sbar    <= 3'd0;
      r1_chk     <= 1'b0;
`ifdef BORDER_OUTLINE_EN
      r1_edge    <= 1'b0;
`endif
    end else begin
      r1_hsync   <= bus.i_hsync;
      r1_hblank  <= bus.i_hblank;
      r1_vsync   <= bus.i_vsync;
      r1_vblank  <= bus.i_vblank;
      r1_visible <= bus.i_visible;
      r1_pattern <= r_pattern;
      r1_solid   <= r_solid;
      r1_bar     <= w_bar;
      r1_sbar    <= w_sbar;
      r1_chk     <= w_chk;
`ifdef BORDER_OUTLINE_EN
      r1_edge    <= w_edge;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 colour selection
  // --------------------------------------------------------------------------
  function automatic logic [8:0] bars_to_rgb(input logic [2:0] b);
    return {{3{b[2]}}, {3{b[1]}}, {3{b[0]}}};
  endfunction

  logic [8:0] w_rgb;

  always_comb begin
    w_rgb = c_BLACK;
    if (r1_visible) begin
      case (r1_pattern)
        c_PAT_SOLID:   w_rgb = r1_solid;
        c_PAT_BARS:    w_rgb = bars_to_rgb(r1_bar);
        c_PAT_CHECKER: w_rgb = r1_chk ? c_WHITE : c_BLACK;
        c_PAT_SCROLL:  w_rgb = bars_to_rgb(r1_sbar);
        default:       w_rgb = c_BLACK;
      endcase
`ifdef BORDER_OUTLINE_EN
      if (r1_edge) begin
        w_rgb = c_WHITE;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 registers (drive the pins directly)
  // --------------------------------------------------------------------------
  logic       r2_hsync;
  logic       r2_hblank;
  logic       r2_vsync;
  logic       r2_vblank;
  logic       r2_visible;
  logic [8:0] r2_rgb;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r2_hsync   <= 1'b0;
      r2_hblank  <= 1'b0;
      r2_vsync   <= 1'b0;
      r2_vblank  <= 1'b0;
      r2_visible <= 1'b0;
      r2_rgb     <= c_BLACK;
    end else begin
      r2_hsync   <= r1_hsync;
      r2_hblank  <= r1_hblank;
      r2_vsync   <= r1_vsync;
      r2_vblank  <= r1_vblank;
      r2_visible <= r1_visible;
      r2_rgb     <= w_rgb;
    end
  end

  assign bus.o_hsync   = r2_hsync;
  assign bus.o_hblank  = r2_hblank;
  assign bus.o_vsync   = r2_vsync;
  assign bus.o_vblank  = r2_vblank;
  assign bus.o_visible = r2_visible;
  assign bus.o_red     = r2_rgb[8:6];
  assign bus.o_grn     = r2_rgb[5:3];
  assign bus.o_blu     = r2_rgb[2:0];
  assign bus.o_frame   = r_frame;

endmodule
`default_nettype wire
